stdp_engine: RTL and testbench

Pipelined spike-timing-dependent plasticity (STDP) weight-update engine for an 18-post × 576-pre synapse array. The weights live in six external dual-port BRAM banks.
- On each time step the engine streams 432 weight words through a read-modify-write pipeline.
- The update uses latched post-synaptic spikes and traces plus streamed pre-synaptic spikes and traces.
- It sits between the neuron/trace layer and the synaptic weight memory.

---
 rtl/stdp_engine_if.sv | 33 +++
 rtl/stdp_engine.sv | 186 ++++++++++++++++++
 tb/tb_stdp_engine.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_engine_if.sv
// rtl/stdp_engine_if.sv - step control, neuron-side streams and dual BRAM port bundle for stdp_engine
interface stdp_engine_if;
   logic         i_run;
   logic         i_sub;
   logic [17:0]  i_post_spike;
   logic [287:0] i_y1_trace;
   logic [287:0] i_y2_trace_buf;
   logic [23:0]  i_pre_spike;
   logic [383:0] i_x_trace;
   logic         o_done;
   logic [53:0]  addr_r;
   logic [5:0]   ce_r;
   logic [5:0]   we_r;
   logic [383:0] d_r;
   logic [383:0] q_r;
   logic [53:0]  addr_w;
   logic [5:0]   ce_w;
   logic [5:0]   we_w;
   logic [383:0] d_w;
   logic [383:0] q_w;

   modport master (
      input  i_run, i_sub, i_post_spike, i_y1_trace, i_y2_trace_buf, i_pre_spike, i_x_trace,
      input  q_r, q_w,
      output o_done, addr_r, ce_r, we_r, d_r, addr_w, ce_w, we_w, d_w
   );

   modport slave (
      output i_run, i_sub, i_post_spike, i_y1_trace, i_y2_trace_buf, i_pre_spike, i_x_trace,
      output q_r, q_w,
      input  o_done, addr_r, ce_r, we_r, d_r, addr_w, ce_w, we_w, d_w
   );
endinterface

// File: rtl/stdp_engine.sv
// rtl/stdp_engine.sv - pipelined STDP read-modify-write engine plus dpbram bank; decay enabled by STDP_SUB_EN
module stdp_engine #(
   parameter int A2P_SH  = 4,
   parameter int A3P_SH  = 20,
   parameter int A2M_SH  = 4,
   parameter int W_MAX   = 65535,
   parameter int SUB_VAL = 1
) (
   input  logic clk,
   input  logic reset,
   stdp_engine_if.master bus
);
   localparam logic [8:0] LAST_K = 9'd431;
   localparam logic signed [39:0] W_MAX_L = 40'(W_MAX);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state, state_nx;

   logic [8:0]   cnt;
   logic [4:0]   grp;
   logic [4:0]   post;
   logic [17:0]  post_lat;
   logic [287:0] y1_lat;
   logic [287:0] y2_lat;
   logic         rd_en;
   logic [8:0]   rd_addr;
   logic         wr_en;
   logic [8:0]   wr_addr;
   logic [383:0] wr_data;
   logic [383:0] upd;

   logic [15:0]  y1_p, y2_p, x, w;
   logic         ps;
   logic [31:0]  prod;
   logic [39:0]  ltp, ltd, dec;
   logic signed [39:0] acc;
   logic         unused_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      rd_addr  = '0;
      case (state)
         S_IDLE:  if (bus.i_run) state_nx = S_WAIT;
         S_WAIT: begin
            rd_en    = 1'b1;
            state_nx = S_RUN;
         end
         S_RUN: begin
            // read runs one word ahead so q_r lines up with the stream element
            if (cnt == LAST_K) begin
               state_nx = S_DRAIN;
            end else begin
               rd_en   = 1'b1;
               rd_addr = cnt + 9'd1;
            end
         end
         S_DRAIN: state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef STDP_SUB_EN
   logic sub_lat;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             sub_lat <= 1'b0;
      else if (state == S_IDLE && bus.i_run) sub_lat <= bus.i_sub;
   end
   assign dec = sub_lat ? 40'(SUB_VAL) : 40'd0;
   assign unused_ok = ^bus.q_w;
`else
   assign dec = 40'd0;
   assign unused_ok = ^{bus.q_w, bus.i_sub};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         grp      <= '0;
         post     <= '0;
         post_lat <= '0;
         y1_lat   <= '0;
         y2_lat   <= '0;
      end else if (state == S_IDLE && bus.i_run) begin
         cnt      <= '0;
         grp      <= '0;
         post     <= '0;
         post_lat <= bus.i_post_spike;
         y1_lat   <= bus.i_y1_trace;
         y2_lat   <= bus.i_y2_trace_buf;
      end else if (state == S_RUN) begin
         cnt <= cnt + 9'd1;
         if (grp == 5'd23) begin
            grp  <= '0;
            post <= post + 5'd1;
         end else begin
            grp <= grp + 5'd1;
         end
      end
   end

   always_comb begin
      upd  = '0;
      y1_p = y1_lat[{post, 4'b0000} +: 16];
      y2_p = y2_lat[{post, 4'b0000} +: 16];
      ps   = post_lat[post];
      x    = '0;
      w    = '0;
      prod = '0;
      ltp  = '0;
      ltd  = '0;
      acc  = '0;
      for (int j = 0; j < 24; j++) begin
         x    = bus.i_x_trace[16*j +: 16];
         w    = bus.q_r[16*j +: 16];
         prod = 32'(x) * 32'(y2_p);
         ltp  = ps ? 40'(x >> A2P_SH) + 40'(prod >> A3P_SH) : '0;
         ltd  = bus.i_pre_spike[j] ? 40'(y1_p >> A2M_SH) : '0;
         acc  = $signed(40'(w) + ltp - ltd - dec);
         if (acc[39])             upd[16*j +: 16] = '0;
         else if (acc > W_MAX_L)  upd[16*j +: 16] = W_MAX_L[15:0];
         else                     upd[16*j +: 16] = acc[15:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= (state == S_RUN);
         if (state == S_RUN) begin
            wr_addr <= cnt;
            wr_data <= upd;
         end
      end
   end

   assign bus.addr_r = {6{rd_addr}};
   assign bus.ce_r   = {6{rd_en}};
   assign bus.we_r   = '0;
   assign bus.d_r    = '0;
   assign bus.addr_w = {6{wr_addr}};
   assign bus.ce_w   = {6{wr_en}};
   assign bus.we_w   = {6{wr_en}};
   assign bus.d_w    = wr_data;
   assign bus.o_done = (state == S_DONE);
endmodule

module dpbram #(
   parameter int DWIDTH   = 64,
   parameter int AWIDTH   = 9,
   parameter int MEM_SIZE = 432
) (
   input  logic              clk,
   input  logic [AWIDTH-1:0] addr0,
   input  logic              ce0,
   input  logic              we0,
   input  logic [DWIDTH-1:0] d0,
   output logic [DWIDTH-1:0] q0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic              ce1,
   input  logic              we1,
   input  logic [DWIDTH-1:0] d1,
   output logic [DWIDTH-1:0] q1
);
   logic [DWIDTH-1:0] ram [0:MEM_SIZE-1];

   always_ff @(posedge clk) begin
      if (ce0) begin
         if (we0) ram[addr0] <= d0;
         else     q0 <= ram[addr0];
      end
      if (ce1) begin
         if (we1) ram[addr1] <= d1;
         else     q1 <= ram[addr1];
      end
   end
endmodule

// File: tb/tb_stdp_engine.sv
// tb/tb_stdp_engine.sv - randomized bench for stdp_engine against a per-synapse STDP model
module tb_stdp_engine;
   localparam int A2P = 4, A3P = 20, A2M = 4, WMAX = 65535, SUBV = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stdp_engine_if bus();
   stdp_engine #(.A2P_SH(A2P), .A3P_SH(A3P), .A2M_SH(A2M), .W_MAX(WMAX), .SUB_VAL(SUBV))
      dut (.clk(clk), .reset(reset), .bus(bus.master));

   logic         tb_mode, tb_we;
   logic [8:0]   tb_addr;
   logic [383:0] tb_d, q0_all, q1_all;

   genvar b;
   generate
      for (b = 0; b < 6; b++) begin : g_bank
         dpbram #(.DWIDTH(64), .AWIDTH(9), .MEM_SIZE(432)) u_bank (
            .clk(clk),
            .addr0(tb_mode ? tb_addr : bus.addr_r[9*b +: 9]),
            .ce0(tb_mode ? 1'b1 : bus.ce_r[b]),
            .we0(tb_mode ? 1'b0 : bus.we_r[b]),
            .d0(bus.d_r[64*b +: 64]),
            .q0(q0_all[64*b +: 64]),
            .addr1(tb_mode ? tb_addr : bus.addr_w[9*b +: 9]),
            .ce1(tb_mode ? tb_we : bus.ce_w[b]),
            .we1(tb_mode ? tb_we : bus.we_w[b]),
            .d1(tb_mode ? tb_d[64*b +: 64] : bus.d_w[64*b +: 64]),
            .q1(q1_all[64*b +: 64]));
      end
   endgenerate
   assign bus.q_r = q0_all;
   assign bus.q_w = q1_all;

   int checks = 0, errors = 0;
   int done_cnt = 0;
   always @(posedge clk) if (bus.o_done === 1'b1) done_cnt <= done_cnt + 1;

   int m_post[18], m_y1[18], m_y2[18], m_pre[576], m_x[576], m_w[18][576], m_sub;

   function automatic int new_w(int p, int n);
      longint acc = m_w[p][n];
      if (m_post[p] != 0) acc += (m_x[n] >> A2P) + ((longint'(m_x[n]) * m_y2[p]) >> A3P);
      if (m_pre[n] != 0) acc -= m_y1[p] >> A2M;
`ifdef STDP_SUB_EN
      if (m_sub != 0) acc -= SUBV;
`endif
      if (acc < 0) acc = 0;
      if (acc > WMAX) acc = WMAX;
      return int'(acc);
   endfunction

   task automatic clear_model();
      for (int p = 0; p < 18; p++) begin
         m_post[p] = 0; m_y1[p] = 0; m_y2[p] = 0;
         for (int n = 0; n < 576; n++) m_w[p][n] = 0;
      end
      for (int n = 0; n < 576; n++) begin m_pre[n] = 0; m_x[n] = 0; end
      m_sub = 0;
   endtask

   task automatic randomize_model(input int density);
      for (int p = 0; p < 18; p++) begin
         m_post[p] = ($urandom_range(0, 99) < density) ? 1 : 0;
         m_y1[p] = $urandom_range(0, 65535);
         m_y2[p] = $urandom_range(0, 65535);
         for (int n = 0; n < 576; n++) m_w[p][n] = $urandom_range(0, 65535);
      end
      for (int n = 0; n < 576; n++) begin
         m_pre[n] = ($urandom_range(0, 99) < density) ? 1 : 0;
         m_x[n] = $urandom_range(0, 65535);
      end
      m_sub = $urandom_range(0, 1);
   endtask

   task automatic load_mem();
      tb_mode = 1'b1;
      for (int k = 0; k < 432; k++) begin
         @(negedge clk);
         for (int j = 0; j < 24; j++) tb_d[16*j +: 16] = 16'(m_w[k/24][24*(k%24)+j]);
         tb_addr = 9'(k);
         tb_we = 1'b1;
      end
      @(negedge clk);
      tb_we = 1'b0;
      tb_mode = 1'b0;
   endtask

   task automatic check_mem(input string name, input int upto);
      logic [383:0] exp_word;
      tb_mode = 1'b1;
      tb_we = 1'b0;
      for (int k = 0; k < 432; k++) begin
         @(negedge clk);
         tb_addr = 9'(k);
         for (int j = 0; j < 24; j++)
            exp_word[16*j +: 16] = (k < upto) ? 16'(new_w(k/24, 24*(k%24)+j))
                                              : 16'(m_w[k/24][24*(k%24)+j]);
         @(negedge clk);
         checks++;
         if (q0_all !== exp_word) begin
            errors++;
            $display("FAIL %s word %0d: got %h expected %h", name, k, q0_all, exp_word);
         end
      end
      tb_mode = 1'b0;
   endtask

   task automatic run_step(input string name, input int abort_at, input int stray_run);
      int d0, n, early, found;
      d0 = done_cnt;
      early = 0;
      for (int p = 0; p < 18; p++) begin
         bus.i_post_spike[p] = m_post[p][0];
         bus.i_y1_trace[16*p +: 16] = 16'(m_y1[p]);
         bus.i_y2_trace_buf[16*p +: 16] = 16'(m_y2[p]);
      end
      bus.i_sub = m_sub[0];
      @(negedge clk);
      bus.i_run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_run = 1'b0;
      bus.i_post_spike = 18'($urandom);
      bus.i_y1_trace = {9{$urandom}};
      bus.i_y2_trace_buf = {9{$urandom}};
      bus.i_sub = ~bus.i_sub;
      @(posedge clk);
      for (int k = 0; k < 432; k++) begin
         @(negedge clk);
         if (bus.o_done !== 1'b0) early++;
         if (k == abort_at) begin
            reset = 1'b1;
            break;
         end
         for (int j = 0; j < 24; j++) begin
            bus.i_pre_spike[j] = m_pre[24*(k%24)+j][0];
            bus.i_x_trace[16*j +: 16] = 16'(m_x[24*(k%24)+j]);
         end
         bus.i_run = (k == stray_run) ? 1'b1 : 1'b0;
         @(posedge clk);
      end
      bus.i_run = 1'b0;
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL %s early_done: got %0d high cycles expected 0", name, early);
      end
      if (abort_at >= 0) begin
         @(negedge clk);
         checks++;
         if (bus.ce_w !== 6'b0 || bus.ce_r !== 6'b0 || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s abort_outputs: ce_w=%b ce_r=%b done=%b expected 0", name, bus.ce_w, bus.ce_r, bus.o_done);
         end
         reset = 1'b0;
         repeat (8) @(negedge clk);
         checks++;
         if (done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL %s abort_done: got %0d pulses expected 0", name, done_cnt - d0);
         end
         return;
      end
      n = 433;
      found = 0;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.o_done === 1'b1) begin found = 1; break; end
      end
      checks++;
      if (found == 0 || n != 434) begin
         errors++;
         $display("FAIL %s done_latency: got edge %0d (found=%0d) expected 434", name, n, found);
      end
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.ce_w !== 6'b0 || bus.we_w !== 6'b0 || bus.ce_r !== 6'b0) begin
         errors++;
         $display("FAIL %s post_done_idle: done=%b ce_w=%b we_w=%b ce_r=%b expected 0", name, bus.o_done, bus.ce_w, bus.we_w, bus.ce_r);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - d0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.ce_r !== 6'b0 || bus.ce_w !== 6'b0 || bus.we_w !== 6'b0 ||
          bus.we_r !== 6'b0 || bus.addr_r !== 54'b0 || bus.addr_w !== 54'b0 || bus.d_w !== 384'b0 ||
          bus.d_r !== 384'b0) begin
         errors++;
         $display("FAIL reset_outputs: done=%b ce_r=%b ce_w=%b we_w=%b addr_r=%h addr_w=%h expected all 0",
                  bus.o_done, bus.ce_r, bus.ce_w, bus.we_w, bus.addr_r, bus.addr_w);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_no_spikes();
      randomize_model(0);
      m_sub = 0;
      load_mem();
      run_step("no_spikes", -1, -1);
      check_mem("no_spikes", 432);
   endtask

   task automatic test_ltp_single();
      clear_model();
      m_post[0] = 1;
      for (int n = 0; n < 576; n++) m_x[n] = 256;
      for (int p = 0; p < 18; p++) for (int n = 0; n < 576; n++) m_w[p][n] = 1000;
      load_mem();
      run_step("ltp_single", -1, -1);
      check_mem("ltp_single", 432);
   endtask

   task automatic test_ltd_clamp();
      clear_model();
      m_y1[5] = 160;
      for (int n = 0; n < 576; n++) m_pre[n] = 1;
      for (int p = 0; p < 18; p++) for (int n = 0; n < 576; n++) m_w[p][n] = 3;
      load_mem();
      run_step("ltd_clamp", -1, -1);
      check_mem("ltd_clamp", 432);
   endtask

   task automatic test_ltp_saturate();
      clear_model();
      for (int p = 0; p < 18; p++) begin
         m_post[p] = 1; m_y2[p] = 65535;
         for (int n = 0; n < 576; n++) m_w[p][n] = 65000;
      end
      for (int n = 0; n < 576; n++) m_x[n] = 65535;
      load_mem();
      run_step("ltp_saturate", -1, -1);
      check_mem("ltp_saturate", 432);
   endtask

   task automatic test_sub();
      clear_model();
      m_sub = 1;
      for (int p = 0; p < 18; p++) for (int n = 0; n < 576; n++) m_w[p][n] = 10;
      load_mem();
      run_step("sub", -1, -1);
      check_mem("sub", 432);
   endtask

   task automatic test_random();
      for (int it = 0; it < 2; it++) begin
         randomize_model(50);
         load_mem();
         run_step("random", -1, $urandom_range(50, 400));
         check_mem("random", 432);
      end
   endtask

   task automatic test_abort();
      randomize_model(50);
      load_mem();
      run_step("abort", 200, -1);
      check_mem("abort", 199);
   endtask

   task automatic test_back_to_back();
      randomize_model(30);
      load_mem();
      run_step("after_abort", -1, -1);
      check_mem("after_abort", 432);
   endtask

   initial begin
      tb_mode = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_d = '0;
      bus.i_run = 1'b0; bus.i_sub = 1'b0; bus.i_post_spike = '0;
      bus.i_y1_trace = '0; bus.i_y2_trace_buf = '0; bus.i_pre_spike = '0; bus.i_x_trace = '0;
      test_reset();
      test_no_spikes();
      test_ltp_single();
      test_ltd_clamp();
      test_ltp_saturate();
      test_sub();
      test_random();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
